// File: rtl/demux_memoria_buffer.sv
// rtl/demux_memoria_buffer.sv - 1:2 stream demux with a DEPTH-entry FIFO and registered head per lane
// Optional DEMUX_AUTO_SEL_EN: round-robin lane choice from an internal toggle instead of selector.
module demux_memoria_buffer #(
    parameter int DATA_W = 2,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    input  logic              selector,
    output logic              ready_out,
    output logic [DATA_W-1:0] data_out0,
    output logic              valid_out0,
    input  logic              ready_in0,
    output logic [DATA_W-1:0] data_out1,
    output logic              valid_out1,
    input  logic              ready_in1,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        LANE_EMPTY   = 2'd0,
        LANE_PARTIAL = 2'd1,
        LANE_FULL    = 2'd2
    } lane_state_t;

    logic [DATA_W-1:0] mem        [2][DEPTH];
    logic [PTR_W-1:0]  wr_ptr     [2];
    logic [PTR_W-1:0]  rd_ptr     [2];
    logic [PTR_W-1:0]  rd_ptr_inc [2];
    logic [CNT_W-1:0]  count      [2];
    logic [CNT_W-1:0]  count_next [2];
    logic [DATA_W-1:0] head       [2];
    logic [DATA_W-1:0] head_next  [2];
    lane_state_t       lane_state [2];
    logic              lane_ready [2];
    logic              push       [2];
    logic              pop        [2];
    logic              lane_sel;
    logic              push_any;

`ifdef DEMUX_AUTO_SEL_EN
    logic toggle;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            toggle <= 1'b0;
        end else if (push_any) begin
            toggle <= ~toggle;
        end
    end

    assign lane_sel = toggle;
`else
    assign lane_sel = selector;
`endif

    assign lane_ready[0] = ready_in0;
    assign lane_ready[1] = ready_in1;

    // Lane state is a pure decode of the occupancy count.
    always_comb begin
        for (int l = 0; l < 2; l++) begin
            lane_state[l] = LANE_PARTIAL;
            if (count[l] == '0) begin
                lane_state[l] = LANE_EMPTY;
            end else if (count[l] == CNT_W'(DEPTH)) begin
                lane_state[l] = LANE_FULL;
            end
        end
    end

    // A full lane refuses input even if it pops this cycle.
    assign ready_out = (lane_state[lane_sel] != LANE_FULL);
    assign push_any  = valid_in && ready_out;

    always_comb begin
        for (int l = 0; l < 2; l++) begin
            push[l]       = push_any && (lane_sel == 1'(l));
            pop[l]        = (lane_state[l] != LANE_EMPTY) && lane_ready[l];
            rd_ptr_inc[l] = rd_ptr[l] + 1'b1;
            count_next[l] = count[l];
            head_next[l]  = head[l];
            case ({push[l], pop[l]})
                2'b10:   count_next[l] = count[l] + 1'b1;
                2'b01:   count_next[l] = count[l] - 1'b1;
                default: count_next[l] = count[l];
            endcase
            // The word being written only becomes head when nothing older remains.
            if (push[l] && ((count[l] == '0) || (pop[l] && count[l] == CNT_W'(1)))) begin
                head_next[l] = data_in;
            end else if (pop[l] && count[l] > CNT_W'(1)) begin
                head_next[l] = mem[l][rd_ptr_inc[l]];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (push[l]) begin
                mem[l][wr_ptr[l]] <= data_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int l = 0; l < 2; l++) begin
                wr_ptr[l] <= '0;
                rd_ptr[l] <= '0;
                count[l]  <= '0;
                head[l]   <= '0;
            end
            drop_cnt <= '0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (push[l]) begin
                    wr_ptr[l] <= wr_ptr[l] + 1'b1;
                end
                if (pop[l]) begin
                    rd_ptr[l] <= rd_ptr_inc[l];
                end
                count[l] <= count_next[l];
                head[l]  <= head_next[l];
            end
            if (valid_in && !ready_out && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    assign data_out0  = head[0];
    assign data_out1  = head[1];
    assign valid_out0 = (lane_state[0] != LANE_EMPTY);
    assign valid_out1 = (lane_state[1] != LANE_EMPTY);

endmodule
